// File: rtl/apb_slave_ctrl.sv
// ---------------------------------------------------------------------------
// apb_slave_ctrl
//
// APB slave front-end that turns each APB transfer into a single-cycle
// rd/wr request on a simple back-end bus, then waits for ack/err and
// finishes the APB access with pready/pslverr. Addresses outside
// [ADDR_LO, ADDR_HI] complete with an error and never reach the back end.
//
// Optional feature (macro APB_SLAVE_TIMEOUT_EN):
//   defined   - 8-bit wait counter forces an error completion after
//               TIMEOUT_CYCLES back-end cycles without ack.
//   undefined - no counter; WAIT holds until ack or psel drops.
//
// Ports
//   pclk, prst           clock, asynchronous active-high reset
//   psel, penable,
//   pwrite, paddr,
//   pwdata, pstrb        APB request
//   prdata, pready,
//   pslverr              APB response (all registered)
//   addr, wdata,
//   b_strobe             back-end request fields, latched in the setup phase
//   rd, wr               back-end one-cycle request pulses
//   rdata, ack, err      back-end response; err is valid with ack
//
// FSM
//   state   | meaning
//   IDLE    | waiting for an APB setup phase
//   REQ     | rd/wr pulse is out, ack sampled, range error resolved
//   WAIT    | waiting for ack (or timeout / psel drop)
//   DONE    | pready high for one cycle, pslverr = error flag
// ---------------------------------------------------------------------------
module apb_slave_ctrl #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_LO        = 0,
    parameter int ADDR_HI        = 12'hFFF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    prst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] b_strobe,
    output logic                    rd,
    output logic                    wr,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    ack,
    input  logic                    err
);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("apb_slave_ctrl: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_slave_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Range check is done as an offset compare one bit wider than the
    // address: a borrow (paddr < ADDR_LO) sets the MSB and fails the
    // compare, and no comparison degenerates to a constant.
    localparam logic [ADDR_WIDTH:0] ADDR_BASE = ADDR_LO[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ADDR_SPAN = ADDR_HI[ADDR_WIDTH:0] - ADDR_LO[ADDR_WIDTH:0];

    state_t            r_state;
    logic              r_write;
    logic              r_in_range;
`ifdef APB_SLAVE_TIMEOUT_EN
    logic [7:0]        r_tmo_cnt;
`endif

    logic [ADDR_WIDTH:0] w_offset;
    logic                w_in_range;
    logic                w_abort;
    logic                w_oor;
    logic                w_tmo;
    logic                w_done;
    logic                w_done_err;

    assign w_offset   = {1'b0, paddr} - ADDR_BASE;
    assign w_in_range = (w_offset <= ADDR_SPAN);

    always_comb begin
        w_abort = ~psel;
        w_oor   = (r_state == ST_REQ) && !r_in_range;
`ifdef APB_SLAVE_TIMEOUT_EN
        w_tmo   = (r_tmo_cnt == TIMEOUT_CYCLES[7:0]);
`else
        w_tmo   = 1'b0;
`endif
        // ack wins over a timeout landing in the same cycle
        w_done     = ~w_abort & (w_oor | ack | w_tmo);
        w_done_err = w_oor | (ack ? err : 1'b1);
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_in_range <= 1'b0;
            prdata     <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            b_strobe   <= '0;
            rd         <= 1'b0;
            wr         <= 1'b0;
`ifdef APB_SLAVE_TIMEOUT_EN
            r_tmo_cnt  <= '0;
`endif
        end else begin
            rd      <= 1'b0;
            wr      <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        addr       <= paddr;
                        wdata      <= pwdata;
                        b_strobe   <= pstrb;
                        r_write    <= pwrite;
                        r_in_range <= w_in_range;
                        // request pulse lands in the REQ cycle; none for out-of-range
                        rd         <= w_in_range & ~pwrite;
                        wr         <= w_in_range & pwrite;
`ifdef APB_SLAVE_TIMEOUT_EN
                        r_tmo_cnt  <= '0;
`endif
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_done) begin
                        r_state <= ST_DONE;
                        pready  <= 1'b1;
                        pslverr <= w_done_err;
                        if (!r_write) begin
                            prdata <= w_done_err ? '0 : rdata;
                        end
                    end else begin
                        r_state <= ST_WAIT;
`ifdef APB_SLAVE_TIMEOUT_EN
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_ctrl
//
// Self-checking bench for apb_slave_ctrl (ADDR_HI = 0x0FF, TIMEOUT_CYCLES = 4).
// Expected completions are computed from the stimulus and queued; each test
// task pops them as the DUT finishes the transfer and compares inline.
// Builds with or without APB_SLAVE_TIMEOUT_EN; expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_apb_slave_ctrl;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          pclk = 1'b0;
    logic          prst;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    b_strobe;
    logic          rd, wr;
    logic [DW-1:0] rdata;
    logic          ack, err;

    always #5 pclk = ~pclk;

    apb_slave_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .ADDR_LO       (0),
        .ADDR_HI       (12'h0FF),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk    (pclk),
        .prst    (prst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .addr    (addr),
        .wdata   (wdata),
        .b_strobe(b_strobe),
        .rd      (rd),
        .wr      (wr),
        .rdata   (rdata),
        .ack     (ack),
        .err     (err)
    );

    typedef struct {
        logic        w;
        logic [11:0] a;
        int          dly;   // access cycles before ack; -1 = never
        logic        e;
        logic [31:0] d;     // pwdata for writes, rdata for reads
        logic [3:0]  s;
    } stim_t;

    typedef struct {
        int          lat;   // access cycle carrying pready; 0 = none
        logic        err;
        logic [31:0] prd;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_prdata = '0;

    int          obs_lat, obs_nrd, obs_nwr;
    logic        obs_err;
    logic [31:0] obs_prd, obs_wdata;
    logic [11:0] obs_addr;
    logic [3:0]  obs_strb;

    function automatic void push_exp(input stim_t s);
        exp_t x;
        logic inr, tmo;
        inr = (s.a <= 12'h0FF);
`ifdef APB_SLAVE_TIMEOUT_EN
        tmo = (s.dly < 0) || (s.dly > TMO);
`else
        tmo = (s.dly < 0);
`endif
        x.nrd = (inr && !s.w) ? 1 : 0;
        x.nwr = (inr && s.w) ? 1 : 0;
        x.lat = 0;
        x.err = 1'b0;
        if (!inr) begin
            x.lat = 2;
            x.err = 1'b1;
            if (!s.w) m_prdata = '0;
        end else if (!tmo) begin
            x.lat = s.dly + 2;
            x.err = s.e;
            if (!s.w) m_prdata = s.e ? 32'h0 : s.d;
        end else begin
`ifdef APB_SLAVE_TIMEOUT_EN
            x.lat = TMO + 2;
            x.err = 1'b1;
            if (!s.w) m_prdata = '0;
`endif
        end
        x.prd = m_prdata;
        sb_q.push_back(x);
    endfunction

    // Entered and left at posedge+1. Leaves psel low in the cycle after the
    // completion, so a following call issues its setup right after DONE.
    task automatic do_xfer(input stim_t s, input int max_wait);
        psel = 1'b1; penable = 1'b0; pwrite = s.w; paddr = s.a;
        pwdata = s.w ? s.d : 32'h0; pstrb = s.s;
        obs_lat = 0; obs_nrd = 0; obs_nwr = 0;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int c = 1; c <= max_wait; c++) begin
            ack   = (s.dly == c - 1);
            err   = s.e;
            rdata = s.w ? 32'h0 : s.d;
            @(negedge pclk);
            if (c == 1) begin
                obs_addr = addr; obs_wdata = wdata; obs_strb = b_strobe;
            end
            obs_nrd += int'(rd);
            obs_nwr += int'(wr);
            obs_err = pslverr;
            obs_prd = prdata;
            if (pready) obs_lat = c;
            @(posedge pclk); #1;
            if (obs_lat != 0) break;
        end
        ack = 1'b0; err = 1'b0; psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({prdata, pready, pslverr, addr, wdata, b_strobe, rd, wr} !== '0)
            $display("FAIL reset_outputs: actual prdata=%h pready=%b pslverr=%b addr=%h wdata=%h strb=%b rd=%b wr=%b required all 0",
                     prdata, pready, pslverr, addr, wdata, b_strobe, rd, wr);
        else n_pass++;
        @(negedge pclk);
        n_checks++;
        if ({pready, rd, wr} !== 3'b000)
            $display("FAIL reset_held: actual pready=%b rd=%b wr=%b required 0", pready, rd, wr);
        else n_pass++;
        @(posedge pclk); #1;
        prst = 1'b0;
    endtask

    task automatic test_read();
        stim_t t[2] = '{'{1'b0, 12'h010, 0, 1'b0, 32'hDEADBEEF, 4'hF},
                        '{1'b0, 12'h0A4, 1, 1'b0, 32'h0F0F_1234, 4'hF}};
        exp_t e;
        foreach (t[i]) push_exp(t[i]);
        foreach (t[i]) begin
            do_xfer(t[i], 20);
            e = sb_q.pop_front();
            n_checks++; if (obs_lat !== e.lat) $display("FAIL read_lat[%0d]: actual %0d required %0d", i, obs_lat, e.lat); else n_pass++;
            n_checks++; if (obs_err !== e.err) $display("FAIL read_pslverr[%0d]: actual %b required %b", i, obs_err, e.err); else n_pass++;
            n_checks++; if (obs_prd !== e.prd) $display("FAIL read_prdata[%0d]: actual %h required %h", i, obs_prd, e.prd); else n_pass++;
            n_checks++; if (obs_nrd !== e.nrd || obs_nwr !== e.nwr) $display("FAIL read_pulses[%0d]: actual rd=%0d wr=%0d required rd=%0d wr=%0d", i, obs_nrd, obs_nwr, e.nrd, e.nwr); else n_pass++;
            n_checks++; if (obs_addr !== t[i].a) $display("FAIL read_addr[%0d]: actual %h required %h", i, obs_addr, t[i].a); else n_pass++;
        end
    endtask

    task automatic test_write();
        stim_t t = '{1'b1, 12'h020, 3, 1'b0, 32'h12345678, 4'b0101};
        exp_t e;
        push_exp(t);
        do_xfer(t, 20);
        e = sb_q.pop_front();
        n_checks++; if (obs_lat !== e.lat) $display("FAIL write_lat: actual %0d required %0d", obs_lat, e.lat); else n_pass++;
        n_checks++; if (obs_err !== e.err) $display("FAIL write_pslverr: actual %b required %b", obs_err, e.err); else n_pass++;
        n_checks++; if (obs_prd !== e.prd) $display("FAIL write_prdata_held: actual %h required %h", obs_prd, e.prd); else n_pass++;
        n_checks++; if (obs_nrd !== e.nrd || obs_nwr !== e.nwr) $display("FAIL write_pulses: actual rd=%0d wr=%0d required rd=%0d wr=%0d", obs_nrd, obs_nwr, e.nrd, e.nwr); else n_pass++;
        n_checks++; if (obs_wdata !== t.d) $display("FAIL write_wdata: actual %h required %h", obs_wdata, t.d); else n_pass++;
        n_checks++; if (obs_strb !== t.s) $display("FAIL write_strobe: actual %b required %b", obs_strb, t.s); else n_pass++;
        n_checks++; if (obs_addr !== t.a) $display("FAIL write_addr: actual %h required %h", obs_addr, t.a); else n_pass++;
    endtask

    task automatic test_addr_range();
        stim_t t[3] = '{'{1'b0, 12'h0FF, 0, 1'b0, 32'h13579BDF, 4'hF},
                        '{1'b0, 12'h100, 0, 1'b0, 32'hAAAA5555, 4'hF},
                        '{1'b1, 12'hFFF, 0, 1'b0, 32'h01020304, 4'hF}};
        exp_t e;
        foreach (t[i]) push_exp(t[i]);
        foreach (t[i]) begin
            do_xfer(t[i], 20);
            e = sb_q.pop_front();
            n_checks++; if (obs_lat !== e.lat) $display("FAIL range_lat[%0d]: actual %0d required %0d", i, obs_lat, e.lat); else n_pass++;
            n_checks++; if (obs_err !== e.err) $display("FAIL range_pslverr[%0d]: actual %b required %b", i, obs_err, e.err); else n_pass++;
            n_checks++; if (obs_prd !== e.prd) $display("FAIL range_prdata[%0d]: actual %h required %h", i, obs_prd, e.prd); else n_pass++;
            n_checks++; if (obs_nrd !== e.nrd || obs_nwr !== e.nwr) $display("FAIL range_pulses[%0d]: actual rd=%0d wr=%0d required rd=%0d wr=%0d", i, obs_nrd, obs_nwr, e.nrd, e.nwr); else n_pass++;
        end
    endtask

    task automatic test_err_resp();
        stim_t t[3] = '{'{1'b0, 12'h060, 1, 1'b0, 32'h5555AAAA, 4'hF},
                        '{1'b0, 12'h064, 2, 1'b1, 32'hFFFF0000, 4'hF},
                        '{1'b1, 12'h068, 0, 1'b1, 32'h87654321, 4'b0011}};
        exp_t e;
        foreach (t[i]) push_exp(t[i]);
        foreach (t[i]) begin
            do_xfer(t[i], 20);
            e = sb_q.pop_front();
            n_checks++; if (obs_lat !== e.lat) $display("FAIL errresp_lat[%0d]: actual %0d required %0d", i, obs_lat, e.lat); else n_pass++;
            n_checks++; if (obs_err !== e.err) $display("FAIL errresp_pslverr[%0d]: actual %b required %b", i, obs_err, e.err); else n_pass++;
            n_checks++; if (obs_prd !== e.prd) $display("FAIL errresp_prdata[%0d]: actual %h required %h", i, obs_prd, e.prd); else n_pass++;
            n_checks++; if (obs_nrd !== e.nrd || obs_nwr !== e.nwr) $display("FAIL errresp_pulses[%0d]: actual rd=%0d wr=%0d required rd=%0d wr=%0d", i, obs_nrd, obs_nwr, e.nrd, e.nwr); else n_pass++;
        end
    endtask

    // never-acked read, then ack landing exactly on the timeout threshold
    task automatic test_timeout();
        stim_t t[2] = '{'{1'b0, 12'h070, -1,  1'b0, 32'h11112222, 4'hF},
                        '{1'b0, 12'h074, TMO, 1'b0, 32'hCAFEF00D, 4'hF}};
        exp_t e;
        foreach (t[i]) push_exp(t[i]);
        foreach (t[i]) begin
            do_xfer(t[i], 100);
            e = sb_q.pop_front();
            n_checks++; if (obs_lat !== e.lat) $display("FAIL timeout_lat[%0d]: actual %0d required %0d", i, obs_lat, e.lat); else n_pass++;
            n_checks++; if (obs_err !== e.err) $display("FAIL timeout_pslverr[%0d]: actual %b required %b", i, obs_err, e.err); else n_pass++;
            n_checks++; if (obs_prd !== e.prd) $display("FAIL timeout_prdata[%0d]: actual %h required %h", i, obs_prd, e.prd); else n_pass++;
            n_checks++; if (obs_nrd !== e.nrd || obs_nwr !== e.nwr) $display("FAIL timeout_pulses[%0d]: actual rd=%0d wr=%0d required rd=%0d wr=%0d", i, obs_nrd, obs_nwr, e.nrd, e.nwr); else n_pass++;
            @(posedge pclk); #1;
        end
    endtask

    // psel drops in WAIT, then a late ack arrives and must be ignored
    task automatic test_abort();
        stim_t t  = '{1'b0, 12'h050, -1, 1'b0, 32'h99998888, 4'hF};
        stim_t t2 = '{1'b0, 12'h054, 0,  1'b0, 32'h24681357, 4'hF};
        exp_t  e;
        int    seen;
        sb_q.push_back('{lat: 0, err: 1'b0, prd: m_prdata, nrd: 1, nwr: 0});
        do_xfer(t, 3);
        e = sb_q.pop_front();
        n_checks++; if (obs_lat !== e.lat) $display("FAIL abort_no_ready: actual %0d required %0d", obs_lat, e.lat); else n_pass++;
        n_checks++; if (obs_nrd !== e.nrd || obs_nwr !== e.nwr) $display("FAIL abort_pulses: actual rd=%0d wr=%0d required rd=%0d wr=%0d", obs_nrd, obs_nwr, e.nrd, e.nwr); else n_pass++;
        @(posedge pclk); #1;
        ack = 1'b1; err = 1'b1; rdata = 32'hFFFFFFFF;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            seen += int'(pready) + int'(pslverr) + int'(rd) + int'(wr);
            @(posedge pclk); #1;
            ack = 1'b0; err = 1'b0;
        end
        n_checks++; if (seen !== 0) $display("FAIL abort_late_ack: actual %0d active output cycles required 0", seen); else n_pass++;
        n_checks++; if (prdata !== e.prd) $display("FAIL abort_prdata_held: actual %h required %h", prdata, e.prd); else n_pass++;
        push_exp(t2);
        do_xfer(t2, 20);
        e = sb_q.pop_front();
        n_checks++; if (obs_lat !== e.lat) $display("FAIL abort_next_lat: actual %0d required %0d", obs_lat, e.lat); else n_pass++;
        n_checks++; if (obs_prd !== e.prd) $display("FAIL abort_next_prdata: actual %h required %h", obs_prd, e.prd); else n_pass++;
    endtask

    task automatic test_ack_idle();
        int seen = 0;
        ack = 1'b1; err = 1'b1; rdata = 32'h76543210;
        for (int c = 0; c < 2; c++) begin
            @(negedge pclk);
            seen += int'(pready) + int'(pslverr) + int'(rd) + int'(wr);
            @(posedge pclk); #1;
        end
        ack = 1'b0; err = 1'b0;
        n_checks++; if (seen !== 0) $display("FAIL ack_idle_outputs: actual %0d active output cycles required 0", seen); else n_pass++;
        n_checks++; if (prdata !== m_prdata) $display("FAIL ack_idle_prdata: actual %h required %h", prdata, m_prdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        stim_t t[4];
        exp_t  e;
        for (int i = 0; i < 4; i++) begin
            t[i].w   = logic'(i % 2);
            t[i].a   = 12'(($urandom_range(0, 63)) * 4);
            t[i].dly = $urandom_range(0, 2);
            t[i].e   = 1'b0;
            t[i].d   = $urandom;
            t[i].s   = 4'($urandom_range(0, 15));
        end
        foreach (t[i]) push_exp(t[i]);
        foreach (t[i]) begin
            do_xfer(t[i], 20);
            e = sb_q.pop_front();
            n_checks++; if (obs_lat !== e.lat) $display("FAIL b2b_lat[%0d]: actual %0d required %0d", i, obs_lat, e.lat); else n_pass++;
            n_checks++; if (obs_err !== e.err) $display("FAIL b2b_pslverr[%0d]: actual %b required %b", i, obs_err, e.err); else n_pass++;
            n_checks++; if (obs_prd !== e.prd) $display("FAIL b2b_prdata[%0d]: actual %h required %h", i, obs_prd, e.prd); else n_pass++;
            n_checks++; if (obs_nrd !== e.nrd || obs_nwr !== e.nwr) $display("FAIL b2b_pulses[%0d]: actual rd=%0d wr=%0d required rd=%0d wr=%0d", i, obs_nrd, obs_nwr, e.nrd, e.nwr); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        stim_t t = '{1'b0, 12'h040, 0, 1'b0, 32'h0BADF00D, 4'hF};
        exp_t  e;
        int    seen = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h030;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        @(negedge pclk);
        prst = 1'b1;
        #1;
        n_checks++;
        if ({prdata, pready, pslverr, addr, wdata, b_strobe, rd, wr} !== '0)
            $display("FAIL midreset_outputs: actual prdata=%h pready=%b pslverr=%b addr=%h wdata=%h strb=%b rd=%b wr=%b required all 0",
                     prdata, pready, pslverr, addr, wdata, b_strobe, rd, wr);
        else n_pass++;
        @(posedge pclk); #1;
        prst = 1'b0; psel = 1'b0; penable = 1'b0;
        m_prdata = '0;
        ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge pclk);
            seen += int'(pready) + int'(rd) + int'(wr);
            @(posedge pclk); #1;
            ack = 1'b0;
        end
        n_checks++; if (seen !== 0) $display("FAIL midreset_no_completion: actual %0d active output cycles required 0", seen); else n_pass++;
        push_exp(t);
        do_xfer(t, 20);
        e = sb_q.pop_front();
        n_checks++; if (obs_lat !== e.lat) $display("FAIL midreset_next_lat: actual %0d required %0d", obs_lat, e.lat); else n_pass++;
        n_checks++; if (obs_err !== e.err) $display("FAIL midreset_next_pslverr: actual %b required %b", obs_err, e.err); else n_pass++;
        n_checks++; if (obs_prd !== e.prd) $display("FAIL midreset_next_prdata: actual %h required %h", obs_prd, e.prd); else n_pass++;
        n_checks++; if (obs_nrd !== e.nrd || obs_nwr !== e.nwr) $display("FAIL midreset_next_pulses: actual rd=%0d wr=%0d required rd=%0d wr=%0d", obs_nrd, obs_nwr, e.nrd, e.nwr); else n_pass++;
    endtask

    initial begin
        prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; rdata = '0; ack = 1'b0; err = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_addr_range();
        test_err_resp();
        test_timeout();
        test_abort();
        test_ack_idle();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation time limit reached required finish before it");
        $fatal(1, "watchdog expired");
    end

endmodule
